// File: rtl/spi_mem_if.sv
// Bus between the control unit and spi_mem: request/op-select handshake plus the SPI pins.
interface spi_mem_if;
  logic        spi_executing;
  logic        spi_done;
  logic        rom_read;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_rom_n;
  logic        cs_ram_n;

  modport master (
    output spi_executing, rom_read, ram_read, ram_write, addr, wdata, miso,
    input  spi_done, rdata, sclk, mosi, cs_rom_n, cs_ram_n
  );

  modport slave (
    input  spi_executing, rom_read, ram_read, ram_write, addr, wdata, miso,
    output spi_done, rdata, sclk, mosi, cs_rom_n, cs_ram_n
  );
endinterface

// File: rtl/spi_mem.sv
// SPI mode-0 master for one ROM and one RAM chip: 40-bit cmd/addr/data frames, sclk = clk/2.
// Define SPI_FAST_READ_EN to issue ROM reads as 0x0B fast reads with 8 dummy bits (48-bit frame).
module spi_mem (
  input  logic     clk,
  input  logic     rst,
  input  logic     halt,
  spi_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t      state, state_nx;
  logic        exec_q;
  logic        op_ram;
  logic        op_read;
  logic        phase;
  logic [47:0] tx_sr;
  logic [5:0]  bits_left;
  logic [7:0]  rx_sr;
  logic [7:0]  rdata_q;

  logic        start;
  logic        sel_ram;
  logic        sel_write;
  logic [47:0] frame;
  logic [5:0]  frame_bits;

  // Frame is left-aligned in 48 bits so both frame lengths shift out of tx_sr[47].
  always_comb begin
    sel_write  = bus.ram_write;
    sel_ram    = bus.ram_write | bus.ram_read;
    frame      = {(sel_write ? 8'h02 : 8'h03), 8'h00, bus.addr,
                  (sel_write ? bus.wdata : 8'h00), 8'h00};
    frame_bits = 6'd40;
`ifdef SPI_FAST_READ_EN
    if (!sel_ram) begin
      frame      = {8'h0B, 8'h00, bus.addr, 8'h00, 8'h00};
      frame_bits = 6'd48;
    end
`else
    frame_bits = 6'd40;
`endif
  end

  always_comb begin
    start    = bus.spi_executing & ~exec_q & (state == IDLE);
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   state_nx = SHIFT;
      SHIFT:   if (phase && bits_left == 6'd1) state_nx = HOLD;
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.spi_done = (state == IDLE);
    bus.sclk     = (state == SHIFT) & phase;
    bus.mosi     = ((state == SETUP) || (state == SHIFT)) ? tx_sr[47] : 1'b0;
    bus.cs_rom_n = ~((state != IDLE) & ~op_ram);
    bus.cs_ram_n = ~((state != IDLE) & op_ram);
    bus.rdata    = rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      exec_q    <= 1'b0;
      op_ram    <= 1'b0;
      op_read   <= 1'b0;
      phase     <= 1'b0;
      tx_sr     <= '0;
      bits_left <= '0;
      rx_sr     <= '0;
      rdata_q   <= '0;
    end else if (!halt) begin
      state  <= state_nx;
      exec_q <= bus.spi_executing;
      case (state)
        IDLE: begin
          if (start) begin
            op_ram    <= sel_ram;
            op_read   <= ~sel_write;
            tx_sr     <= frame;
            bits_left <= frame_bits;
            phase     <= 1'b0;
          end
        end
        SHIFT: begin
          phase <= ~phase;
          // miso is taken on the sclk rising cycle; mosi advances as sclk falls.
          if (!phase) begin
            rx_sr <= {rx_sr[6:0], bus.miso};
          end else begin
            tx_sr     <= {tx_sr[46:0], 1'b0};
            bits_left <= bits_left - 6'd1;
          end
        end
        HOLD: begin
          if (op_read) rdata_q <= rx_sr;
        end
        default: ;
      endcase
    end
  end

endmodule
